// File: rtl/fewcore_pkg.sv
// Shared core constants: major opcodes, load/store funct3 codes, memory-stage state.
package fewcore_pkg;
  localparam int XLEN = 32;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {IDLE, REQ} state_e;

  // Lane offset actually used for steering: halves ignore addr[0], words ignore addr[1:0].
  function automatic logic [1:0] lane_lo(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b01:   lane_lo = {a[1], 1'b0};
      2'b10:   lane_lo = 2'b00;
      default: lane_lo = a;
    endcase
  endfunction
endpackage

// File: rtl/memory_access_if.sv
// Data-memory request/ready port; master = pipeline stage, slave = memory.
interface memory_access_if;
  import fewcore_pkg::*;
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [3:0]      mem_be;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_ready;
  logic [XLEN-1:0] mem_rdata;

  modport master (output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                  input  mem_ready, mem_rdata);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                  output mem_ready, mem_rdata);
endinterface

// File: rtl/load_extend.sv
// Picks the addressed byte/half from a read word and sign- or zero-extends it.
module load_extend
  import fewcore_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  output logic [XLEN-1:0] result
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
  assign half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    result = rdata;
    case (funct3)
      F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   result = {24'h0, byte_sel};
      F3_H:    result = {{16{half_sel[15]}}, half_sel};
      F3_HU:   result = {16'h0, half_sel};
      default: result = rdata;
    endcase
  end
endmodule

// File: rtl/memory_access.sv
// Memory pipeline stage: pass-through for ALU ops, request/ready transaction for loads/stores.
// Build option MEM_MISALIGN_TRAP_EN: retire misaligned half/word accesses with misalign=1 instead of accessing.
module memory_access
  import fewcore_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [11:0]            operation,
  input  logic [XLEN-1:0]        resultALU,
  input  logic [4:0]             address_rd,
  input  logic [XLEN-1:0]        content_rs2,
  output logic                   stall,
  memory_access_if.master        mem,
  output logic                   wb_valid,
  output logic                   wb_we,
  output logic [4:0]             wb_rd,
  output logic [XLEN-1:0]        wb_data,
  output logic                   misalign
);
  logic [6:0] opcode;
  logic [2:0] f3;
  logic [1:0] addr_lo, lo_eff;
  logic       is_ld, is_st, f3_ok, trap, mem_go;
  logic [3:0] be_st;
  logic [XLEN-1:0] wdata_st, ld_data;
  logic       unused_op;

  state_e          state_q, state_d;
  logic            mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [3:0]      mem_be_q, mem_be_d;
  logic [4:0]      rd_q, rd_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      lo_q, lo_d;
  logic            wb_valid_q, wb_valid_d, wb_we_q, wb_we_d, misalign_q, misalign_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;

  assign opcode    = operation[6:0];
  assign f3        = operation[9:7];
  assign unused_op = ^operation[11:10];
  assign addr_lo   = resultALU[1:0];
  assign is_ld     = (opcode == OP_LOAD);
  assign is_st     = (opcode == OP_STORE);
  assign f3_ok     = is_ld ? (f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU})
                           : (f3 inside {F3_B, F3_H, F3_W});

`ifdef MEM_MISALIGN_TRAP_EN
  logic mis;
  assign mis  = ((f3[1:0] == 2'b01) && addr_lo[0]) || ((f3 == F3_W) && (addr_lo != 2'b00));
  assign trap = (is_ld || is_st) && f3_ok && mis;
`else
  assign trap = 1'b0;
`endif

  assign mem_go = (state_q == IDLE) && in_valid && (is_ld || is_st) && f3_ok && !trap;
  assign stall  = (state_q == IDLE) ? mem_go : !mem.mem_ready;
  assign lo_eff = lane_lo(f3, addr_lo);

  always_comb begin
    be_st    = 4'b1111;
    wdata_st = content_rs2;
    case (f3)
      F3_B: begin
        be_st    = 4'b0001 << lo_eff;
        wdata_st = {4{content_rs2[7:0]}};
      end
      F3_H: begin
        be_st    = 4'b0011 << lo_eff;
        wdata_st = {2{content_rs2[15:0]}};
      end
      default: ;
    endcase
  end

  load_extend u_ext (
    .rdata   (mem.mem_rdata),
    .funct3  (f3_q),
    .addr_lo (lo_q),
    .result  (ld_data)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rd_d        = rd_q;
    f3_d        = f3_q;
    lo_d        = lo_q;
    wb_valid_d  = 1'b0;
    wb_we_d     = wb_we_q;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    misalign_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_go) begin
          state_d     = REQ;
          mem_req_d   = 1'b1;
          mem_we_d    = is_st;
          mem_addr_d  = {resultALU[XLEN-1:2], 2'b00};
          mem_be_d    = is_st ? be_st : 4'b1111;
          mem_wdata_d = wdata_st;
          rd_d        = address_rd;
          f3_d        = f3;
          lo_d        = lo_eff;
        end else if (in_valid) begin
          // Undefined-funct3 and trapped memory ops land here too and never write rd.
          wb_valid_d = 1'b1;
          wb_rd_d    = address_rd;
          wb_data_d  = resultALU;
          wb_we_d    = (address_rd != 5'd0) && !is_ld && !is_st && (opcode != OP_BRANCH);
          misalign_d = trap;
        end
      end
      REQ: begin
        if (mem.mem_ready) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_we_d    = !mem_we_q && (rd_q != 5'd0);
          wb_data_d  = mem_we_q ? wb_data_q : ld_data;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      rd_q        <= '0;
      f3_q        <= '0;
      lo_q        <= '0;
      wb_valid_q  <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rd_q        <= rd_d;
      f3_q        <= f3_d;
      lo_q        <= lo_d;
      wb_valid_q  <= wb_valid_d;
      wb_we_q     <= wb_we_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      misalign_q  <= misalign_d;
    end
  end

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_be    = mem_be_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign wb_valid      = wb_valid_q;
  assign wb_we         = wb_we_q;
  assign wb_rd         = wb_rd_q;
  assign wb_data       = wb_data_q;
  assign misalign      = misalign_q;
endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: pass-through, store steering, load extension, waits, reset.
module tb_memory_access;
  import fewcore_pkg::*;

  logic        clk = 1'b0;
  logic        reset, in_valid, stall, wb_valid, wb_we, misalign;
  logic [11:0] operation;
  logic [31:0] resultALU, content_rs2, wb_data;
  logic [4:0]  address_rd, wb_rd;
  int          n_err = 0, n_chk = 0;
  int          cnt;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_we, cap_wbv;

  memory_access_if bus ();

  memory_access dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .operation   (operation),
    .resultALU   (resultALU),
    .address_rd  (address_rd),
    .content_rs2 (content_rs2),
    .stall       (stall),
    .mem         (bus),
    .wb_valid    (wb_valid),
    .wb_we       (wb_we),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .misalign    (misalign)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rs2, input logic [4:0] rd);
    in_valid    = 1'b1;
    operation   = {2'b00, f3, opc};
    resultALU   = addr;
    content_rs2 = rs2;
    address_rd  = rd;
  endtask

  // Runs one memory op: counts stall-high cycles, captures the request, retires with rdata.
  task automatic mem_op(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] rs2, input logic [4:0] rd,
                        input int waits, input logic [31:0] rdata);
    present(opc, f3, addr, rs2, rd);
    cnt = 0;
    #1;
    if (stall) cnt++;
    tick;
    chk({tag, "_req"}, 32'(bus.mem_req), 32'd1);
    cap_addr  = bus.mem_addr;
    cap_be    = bus.mem_be;
    cap_wdata = bus.mem_wdata;
    cap_we    = bus.mem_we;
    cap_wbv   = wb_valid;
    for (int i = 0; i < waits; i++) begin
      if (stall) cnt++;
      tick;
    end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = rdata;
    #1;
    chk({tag, "_stall_ready"}, 32'(stall), 32'd0);
    in_valid = 1'b0;
    tick;
    bus.mem_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; operation = '0; resultALU = '0;
    content_rs2 = '0; address_rd = '0; bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    tick; tick;
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_mem_req",  32'(bus.mem_req), 32'd0);
    chk("rst_wb_data",  wb_data, 32'h0);
    chk("rst_mem_be",   32'(bus.mem_be), 32'h0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    reset = 1'b1;

    // ADD pass-through
    present(7'b0110011, 3'b000, 32'h0000_1234, 32'h0, 5'd5);
    #1 chk("add_stall", 32'(stall), 32'd0);
    tick;
    chk("add_wb_valid", 32'(wb_valid), 32'd1);
    chk("add_wb_we",    32'(wb_we), 32'd1);
    chk("add_wb_rd",    32'(wb_rd), 32'd5);
    chk("add_wb_data",  wb_data, 32'h0000_1234);
    address_rd = 5'd0;
    tick;
    chk("add_rd0_valid", 32'(wb_valid), 32'd1);
    chk("add_rd0_we",    32'(wb_we), 32'd0);
    present(OP_BRANCH, 3'b000, 32'h77, 32'h0, 5'd3);
    tick;
    chk("br_we",   32'(wb_we), 32'd0);
    chk("br_data", wb_data, 32'h77);
    in_valid = 1'b0;
    bus.mem_ready = 1'b1;
    tick;
    chk("idle_wb_valid", 32'(wb_valid), 32'd0);
    chk("idle_hold",     wb_data, 32'h77);
    chk("idle_req",      32'(bus.mem_req), 32'd0);
    bus.mem_ready = 1'b0;

    // SB, zero wait
    mem_op("sb", OP_STORE, F3_B, 32'h103, 32'hAABB_CCDD, 5'd1, 0, 32'h0);
    chk("sb_stall_cyc", cnt, 1);
    chk("sb_addr",  cap_addr, 32'h100);
    chk("sb_be",    32'(cap_be), 32'h8);
    chk("sb_wdata", cap_wdata, 32'hDDDD_DDDD);
    chk("sb_we",    32'(cap_we), 32'd1);
    chk("sb_wbv",   32'(wb_valid), 32'd1);
    chk("sb_wbwe",  32'(wb_we), 32'd0);
    chk("sb_req_clr", 32'(bus.mem_req), 32'd0);
    tick;
    chk("sb_pulse", 32'(wb_valid), 32'd0);

    // SH, one wait
    mem_op("sh", OP_STORE, F3_H, 32'h102, 32'h1234_ABCD, 5'd2, 1, 32'h0);
    chk("sh_be",    32'(cap_be), 32'hC);
    chk("sh_wdata", cap_wdata, 32'hABCD_ABCD);
    chk("sh_stall_cyc", cnt, 2);

    // LB / LBU with three wait cycles
    mem_op("lb", OP_LOAD, F3_B, 32'h202, 32'h0, 5'd7, 3, 32'h1280_FF34);
    chk("lb_stall_cyc", cnt, 4);
    chk("lb_be",   32'(cap_be), 32'hF);
    chk("lb_we",   32'(cap_we), 32'd0);
    chk("lb_addr", cap_addr, 32'h200);
    chk("lb_wbv",  32'(wb_valid), 32'd1);
    chk("lb_wbwe", 32'(wb_we), 32'd1);
    chk("lb_rd",   32'(wb_rd), 32'd7);
    chk("lb_data", wb_data, 32'hFFFF_FF80);
    mem_op("lbu", OP_LOAD, F3_BU, 32'h202, 32'h0, 5'd7, 3, 32'h1280_FF34);
    chk("lbu_stall_cyc", cnt, 4);
    chk("lbu_data", wb_data, 32'h0000_0080);

    // LH then LW back to back
    mem_op("lh", OP_LOAD, F3_H, 32'h206, 32'h0, 5'd8, 0, 32'h8001_0000);
    chk("lh_wbv",  32'(wb_valid), 32'd1);
    chk("lh_data", wb_data, 32'hFFFF_8001);
    mem_op("lw", OP_LOAD, F3_W, 32'h300, 32'h0, 5'd9, 0, 32'hCAFE_F00D);
    chk("lw_no_dup", 32'(cap_wbv), 32'd0);
    chk("lw_addr", cap_addr, 32'h300);
    chk("lw_wbv",  32'(wb_valid), 32'd1);
    chk("lw_rd",   32'(wb_rd), 32'd9);
    chk("lw_data", wb_data, 32'hCAFE_F00D);

    // Misaligned LW
`ifdef MEM_MISALIGN_TRAP_EN
    present(OP_LOAD, F3_W, 32'h301, 32'h0, 5'd10);
    #1 chk("mis_stall", 32'(stall), 32'd0);
    tick;
    chk("mis_req",  32'(bus.mem_req), 32'd0);
    chk("mis_wbv",  32'(wb_valid), 32'd1);
    chk("mis_flag", 32'(misalign), 32'd1);
    chk("mis_we",   32'(wb_we), 32'd0);
    in_valid = 1'b0;
    tick;
    chk("mis_pulse", 32'(misalign), 32'd0);
`else
    mem_op("mis", OP_LOAD, F3_W, 32'h301, 32'h0, 5'd10, 1, 32'h1122_3344);
    chk("mis_addr", cap_addr, 32'h300);
    chk("mis_data", wb_data, 32'h1122_3344);
    chk("mis_flag", 32'(misalign), 32'd0);
`endif

    // Undefined funct3 on load opcode
    present(OP_LOAD, 3'b011, 32'h500, 32'h0, 5'd6);
    #1 chk("undef_stall", 32'(stall), 32'd0);
    tick;
    chk("undef_wbv",  32'(wb_valid), 32'd1);
    chk("undef_we",   32'(wb_we), 32'd0);
    chk("undef_req",  32'(bus.mem_req), 32'd0);
    chk("undef_data", wb_data, 32'h500);

    // Reset in the second REQ cycle
    present(OP_LOAD, F3_W, 32'h400, 32'h0, 5'd3);
    tick;
    chk("rq_req", 32'(bus.mem_req), 32'd1);
    tick;
    reset = 1'b0;
    tick;
    chk("rq_mem_req",   32'(bus.mem_req), 32'd0);
    chk("rq_mem_addr",  bus.mem_addr, 32'h0);
    chk("rq_mem_be",    32'(bus.mem_be), 32'h0);
    chk("rq_mem_we",    32'(bus.mem_we), 32'd0);
    chk("rq_mem_wdata", bus.mem_wdata, 32'h0);
    chk("rq_wb_valid",  32'(wb_valid), 32'd0);
    chk("rq_wb_data",   wb_data, 32'h0);
    chk("rq_wb_rd",     32'(wb_rd), 32'd0);
    reset = 1'b1;
    present(7'b0110011, 3'b000, 32'h55, 32'h0, 5'd4);
    tick;
    chk("post_wbv",  32'(wb_valid), 32'd1);
    chk("post_we",   32'(wb_we), 32'd1);
    chk("post_rd",   32'(wb_rd), 32'd4);
    chk("post_data", wb_data, 32'h55);
    in_valid = 1'b0;
    tick;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
